// File: rtl/key_entry.sv
`default_nettype none
// ============================================================================
//  Module   : key_entry
//  Purpose  : Turns single-cycle numpad key events into decimal operands
//             (BCD magnitude + sign) and operator tokens for the calculator
//             core. Tokens leave over a valid/ready handshake. The module
//             also drives the live entry display.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DIGITS      maximum BCD digits per operand (bus width 4*DIGITS)
//    FIFO_DEPTH  key event FIFO depth, power of 2 (KEY_FIFO_EN builds only)
//  Build option
//    KEY_FIFO_EN when defined, key events are buffered in a FIFO_DEPTH FIFO
//                instead of being dropped while a token is pending
//  Ports
//    clock       in   system clock
//    reset_n     in   asynchronous active-low reset
//    key_event   in   {valid, main_kbd, col[1:0], row[1:0]}, 1-cycle pulse
//    tok_valid   out  token available
//    tok_ready   in   downstream accepts token
//    tok_num     out  1 = number token, 0 = operator token
//    tok_op      out  operator code (ADD,SUB,MUL,DIV,MOD,EQ,CLR = 0..6)
//    tok_neg     out  operand sign (never set for a zero magnitude)
//    tok_bcd     out  operand magnitude, BCD, LS digit in [3:0]
//    disp_bcd    out  current entry magnitude
//    disp_neg    out  current entry sign
//    disp_len    out  digits entered, 0..DIGITS
//    key_drop    out  1-cycle pulse: key event lost
//    entry_full  out  1-cycle pulse: digit rejected, entry already full
// ============================================================================
module key_entry #(
  parameter int DIGITS     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [5:0]          key_event,
  output logic                tok_valid,
  input  logic                tok_ready,
  output logic                tok_num,
  output logic [2:0]          tok_op,
  output logic                tok_neg,
  output logic [4*DIGITS-1:0] tok_bcd,
  output logic [4*DIGITS-1:0] disp_bcd,
  output logic                disp_neg,
  output logic [3:0]          disp_len,
  output logic                key_drop,
  output logic                entry_full
);

  localparam int BCD_W = 4 * DIGITS;

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_EMIT_NUM = 2'd1;
  localparam logic [1:0] c_EMIT_OP  = 2'd2;

  localparam logic [2:0] c_OP_ADD = 3'd0;
  localparam logic [2:0] c_OP_SUB = 3'd1;
  localparam logic [2:0] c_OP_MUL = 3'd2;
  localparam logic [2:0] c_OP_DIV = 3'd3;
  localparam logic [2:0] c_OP_MOD = 3'd4;
  localparam logic [2:0] c_OP_EQ  = 3'd5;
  localparam logic [2:0] c_OP_CLR = 3'd6;

  localparam logic [3:0] c_MAX_LEN = 4'(DIGITS);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [BCD_W-1:0] r_bcd;
  logic             r_neg;
  logic [3:0]       r_len;
  logic             r_has;
  logic [2:0]       r_op;

  logic             w_idle;
  logic             w_take;
  logic [4:0]       w_ev;

  assign w_idle = (r_state == c_IDLE);

  // --------------------------------------------------------------------------
  // Event source: either straight from the scanner or through the FIFO.
  // w_take means "an event is consumed this cycle" and already implies IDLE.
  // --------------------------------------------------------------------------
`ifdef KEY_FIFO_EN
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_wr;
  logic             w_rd;

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_rd    = w_idle && !w_empty;
  // A pop in the same cycle frees a slot, so a write into a full FIFO succeeds.
  assign w_wr     = key_event[5] && (!w_full || w_rd);
  assign key_drop = key_event[5] && w_full && !w_rd;

  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_fifo[r_wr_ptr] <= key_event[4:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_take = w_rd;
  assign w_ev   = r_fifo[r_rd_ptr];
`else
  logic w_unused_fifo_depth;
  assign w_unused_fifo_depth = (FIFO_DEPTH != 0);

  assign w_take   = key_event[5] && w_idle;
  assign w_ev     = key_event[4:0];
  assign key_drop = key_event[5] && !w_idle;
`endif

  // --------------------------------------------------------------------------
  // Key decode: {col,row} -> keypad legend, then legend -> action.
  // --------------------------------------------------------------------------
  logic [3:0] w_code;
  logic       w_is_digit;
  logic       w_is_op;
  logic [2:0] w_op_code;
  logic       w_is_neg;
  logic       w_is_bs;
  logic       w_is_ce;
  logic       w_is_ca;

  always_comb begin
    w_code = 4'h0;
    case (w_ev[3:0])
      4'd0:  w_code = 4'h1;
      4'd1:  w_code = 4'h4;
      4'd2:  w_code = 4'h7;
      4'd3:  w_code = 4'h0;
      4'd4:  w_code = 4'h2;
      4'd5:  w_code = 4'h5;
      4'd6:  w_code = 4'h8;
      4'd7:  w_code = 4'hF;
      4'd8:  w_code = 4'h3;
      4'd9:  w_code = 4'h6;
      4'd10: w_code = 4'h9;
      4'd11: w_code = 4'hE;
      4'd12: w_code = 4'hA;
      4'd13: w_code = 4'hB;
      4'd14: w_code = 4'hC;
      default: w_code = 4'hD;
    endcase
  end

  always_comb begin
    w_is_digit = 1'b0;
    w_is_op    = 1'b0;
    w_op_code  = c_OP_ADD;
    w_is_neg   = 1'b0;
    w_is_bs    = 1'b0;
    w_is_ce    = 1'b0;
    w_is_ca    = 1'b0;
    if (w_ev[4]) begin
      if (w_code <= 4'd9) begin
        w_is_digit = 1'b1;
      end else begin
        case (w_code)
          4'hA: begin w_is_op = 1'b1; w_op_code = c_OP_ADD; end
          4'hB: begin w_is_op = 1'b1; w_op_code = c_OP_SUB; end
          4'hC: begin w_is_op = 1'b1; w_op_code = c_OP_MUL; end
          4'hD: begin w_is_op = 1'b1; w_op_code = c_OP_DIV; end
          4'hE: begin w_is_op = 1'b1; w_op_code = c_OP_EQ;  end
          default: w_is_ce = 1'b1;
        endcase
      end
    end else begin
      // Alternate keyboard: digit positions and F have no function.
      case (w_code)
        4'hA: begin w_is_op = 1'b1; w_op_code = c_OP_MOD; end
        4'hB: w_is_neg = 1'b1;
        4'hC: begin w_is_op = 1'b1; w_op_code = c_OP_CLR; w_is_ca = 1'b1; end
        4'hD: w_is_bs = 1'b1;
        4'hE: begin w_is_op = 1'b1; w_op_code = c_OP_EQ; end
        default: ;
      endcase
    end
  end

  assign entry_full = w_take && w_is_digit && (r_len == c_MAX_LEN);

  // --------------------------------------------------------------------------
  // Entry register. Edits only happen in IDLE (w_take); the snapshot is
  // frozen while the number token is pending and cleared once it transfers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_bcd <= '0;
      r_neg <= 1'b0;
      r_len <= 4'd0;
      r_has <= 1'b0;
    end else if ((r_state == c_EMIT_NUM) && tok_ready) begin
      r_bcd <= '0;
      r_neg <= 1'b0;
      r_len <= 4'd0;
      r_has <= 1'b0;
    end else if (w_take) begin
      if (w_is_ce || w_is_ca) begin
        r_bcd <= '0;
        r_neg <= 1'b0;
        r_len <= 4'd0;
        r_has <= 1'b0;
      end else if (w_is_neg) begin
        r_neg <= !r_neg;
      end else if (w_is_bs) begin
        if (r_len != 4'd0) begin
          r_bcd <= r_bcd >> 4;
          r_len <= r_len - 4'd1;
        end
      end else if (w_is_digit) begin
        r_has <= 1'b1;
        // Leading zeros are swallowed but still count as an entry.
        if ((r_len != c_MAX_LEN) && !((r_len == 4'd0) && (w_code == 4'd0))) begin
          r_bcd <= {r_bcd[BCD_W-5:0], w_code};
          r_len <= r_len + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op <= c_OP_ADD;
    end else if (w_take && w_is_op) begin
      r_op <= w_op_code;
    end
  end

  // --------------------------------------------------------------------------
  // Token FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_take && w_is_op) begin
          w_state_nxt = (w_is_ca || !r_has) ? c_EMIT_OP : c_EMIT_NUM;
        end
      end
      c_EMIT_NUM: begin
        if (tok_ready) begin
          w_state_nxt = c_EMIT_OP;
        end
      end
      c_EMIT_OP: begin
        if (tok_ready) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    tok_valid = 1'b0;
    tok_num   = 1'b0;
    tok_op    = 3'd0;
    tok_neg   = 1'b0;
    tok_bcd   = '0;
    case (r_state)
      c_EMIT_NUM: begin
        tok_valid = 1'b1;
        tok_num   = 1'b1;
        // A zero magnitude is always sent as positive.
        tok_neg   = r_neg && (r_bcd != '0);
        tok_bcd   = r_bcd;
      end
      c_EMIT_OP: begin
        tok_valid = 1'b1;
        tok_op    = r_op;
      end
      default: ;
    endcase
  end

  assign disp_bcd = r_bcd;
  assign disp_neg = r_neg;
  assign disp_len = r_len;

endmodule
`default_nettype wire
